// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 16-opcode CPU datapath.
// Optional single-step debug mode is compiled in when FSM_STEP_EN is defined.
module cpu_control_fsm #(
   parameter int unsigned MEM_WAIT = 0,
   parameter int unsigned WAIT_W   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opcode,
   input  logic [1:0] status,
   input  logic       resume,
   input  logic       step,
   output logic [3:0] state,
   output logic       halted,
   output logic       status_we,
   output logic [2:0] alu_op,
   output logic       alu_in0,
   output logic [1:0] alu_in1,
   output logic       memory_write,
   output logic [1:0] memory_addr,
   output logic       ins_reg,
   output logic [1:0] reg_data,
   output logic [1:0] reg_addr,
   output logic       regfile_write
);

   localparam logic [3:0] ST_FETCH_0  = 4'h0;
   localparam logic [3:0] ST_FETCH_1  = 4'h1;
   localparam logic [3:0] ST_DECODE_0 = 4'h2;
   localparam logic [3:0] ST_HALT_0   = 4'h3;
   localparam logic [3:0] ST_REG_0    = 4'h4;
   localparam logic [3:0] ST_REG_1    = 4'h5;
   localparam logic [3:0] ST_LD_0     = 4'h6;
   localparam logic [3:0] ST_LD_1     = 4'h7;
   localparam logic [3:0] ST_STR_0    = 4'h8;
   localparam logic [3:0] ST_MOV_0    = 4'h9;
   localparam logic [3:0] ST_MVR_0    = 4'hA;
   localparam logic [3:0] ST_BRANCH_0 = 4'hB;
   localparam logic [3:0] ST_BRANCH_1 = 4'hC;

   // Every instruction retires through this state; single-step parks in STEP_0 first.
`ifdef FSM_STEP_EN
   localparam logic [3:0] ST_STEP_0   = 4'hD;
   localparam logic [3:0] ST_RETIRE   = ST_STEP_0;
`else
   localparam logic [3:0] ST_RETIRE   = ST_FETCH_0;
`endif

   localparam logic [3:0] OP_HALT = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h5;
   localparam logic [3:0] OP_LD   = 4'h6;
   localparam logic [3:0] OP_STR  = 4'h7;
   localparam logic [3:0] OP_MOV  = 4'h8;
   localparam logic [3:0] OP_MVR  = 4'h9;
   localparam logic [3:0] OP_CMP  = 4'hA;
   localparam logic [3:0] OP_B    = 4'hB;
   localparam logic [3:0] OP_BEQ  = 4'hC;
   localparam logic [3:0] OP_BNE  = 4'hD;
   localparam logic [3:0] OP_BLT  = 4'hE;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b011;
   localparam logic [2:0] ALU_SUB  = 3'b100;
   localparam logic       IN0_PC   = 1'b1;
   localparam logic [1:0] IN1_INS  = 2'b01;
   localparam logic [1:0] IN1_ONE  = 2'b10;
   localparam logic [1:0] MA_PC    = 2'b00;
   localparam logic [1:0] MA_OUT0  = 2'b01;
   localparam logic [1:0] MA_OUT1  = 2'b10;
   localparam logic [1:0] RD_IMM   = 2'b00;
   localparam logic [1:0] RD_MEM   = 2'b01;
   localparam logic [1:0] RD_ALU   = 2'b10;
   localparam logic [1:0] RD_OUT1  = 2'b11;
   localparam logic [1:0] RA_D     = 2'b00;
   localparam logic [1:0] RA_PC    = 2'b10;

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

   logic [3:0]        state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic [3:0]        op_q, op_d;
   logic              take_branch;

`ifndef FSM_STEP_EN
   logic unused_step;
   assign unused_step = step;
`endif

   function automatic logic [2:0] reg_alu_op(input logic [3:0] op);
      return (op == OP_CMP) ? ALU_SUB : 3'(op - 4'd1);
   endfunction

   always_comb begin
      take_branch = 1'b0;
      case (op_q)
         OP_B:    take_branch = 1'b1;
         OP_BEQ:  take_branch = status[1];
         OP_BNE:  take_branch = ~status[1];
         OP_BLT:  take_branch = status[0];
         default: take_branch = ~status[1] & ~status[0];
      endcase
   end

   // Wait counter defaults to zero, so it is already clear whenever FETCH_0 or LD_0 is entered.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      op_d    = op_q;
      case (state_q)
         ST_FETCH_0: begin
            if (cnt_q == WAIT_LAST) state_d = ST_FETCH_1;
            else                    cnt_d   = cnt_q + WAIT_ONE;
         end
         ST_FETCH_1: state_d = ST_DECODE_0;
         ST_DECODE_0: begin
            op_d = opcode;
            case (opcode)
               OP_HALT: state_d = ST_HALT_0;
               OP_LD:   state_d = ST_LD_0;
               OP_STR:  state_d = ST_STR_0;
               OP_MOV:  state_d = ST_MOV_0;
               OP_MVR:  state_d = ST_MVR_0;
               OP_CMP:  state_d = ST_REG_0;
               default: state_d = (opcode <= OP_SUB) ? ST_REG_0 : ST_BRANCH_0;
            endcase
         end
         ST_HALT_0:   if (resume) state_d = ST_RETIRE;
         ST_REG_0:    state_d = (op_q == OP_CMP) ? ST_RETIRE : ST_REG_1;
         ST_LD_0: begin
            if (cnt_q == WAIT_LAST) state_d = ST_LD_1;
            else                    cnt_d   = cnt_q + WAIT_ONE;
         end
         ST_BRANCH_0: state_d = take_branch ? ST_BRANCH_1 : ST_RETIRE;
         ST_REG_1, ST_LD_1, ST_STR_0, ST_MOV_0, ST_MVR_0, ST_BRANCH_1:
            state_d = ST_RETIRE;
`ifdef FSM_STEP_EN
         ST_STEP_0:   if (step) state_d = ST_FETCH_0;
`endif
         default:     state_d = ST_FETCH_0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FETCH_0;
         cnt_q   <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      status_we     = 1'b0;
      alu_op        = ALU_AND;
      alu_in0       = 1'b0;
      alu_in1       = 2'b00;
      memory_write  = 1'b0;
      memory_addr   = MA_PC;
      ins_reg       = 1'b0;
      reg_data      = RD_IMM;
      reg_addr      = RA_D;
      regfile_write = 1'b0;
      case (state_q)
         ST_FETCH_0: memory_addr = MA_PC;
         ST_FETCH_1: begin
            ins_reg       = 1'b1;
            alu_in0       = IN0_PC;
            alu_in1       = IN1_ONE;
            alu_op        = ALU_ADD;
            reg_data      = RD_ALU;
            reg_addr      = RA_PC;
            regfile_write = 1'b1;
         end
         ST_REG_0: begin
            alu_op    = reg_alu_op(op_q);
            status_we = 1'b1;
         end
         ST_REG_1: begin
            alu_op        = reg_alu_op(op_q);
            reg_data      = RD_ALU;
            reg_addr      = RA_D;
            regfile_write = 1'b1;
         end
         ST_LD_0: memory_addr = MA_OUT1;
         ST_LD_1: begin
            memory_addr   = MA_OUT1;
            reg_data      = RD_MEM;
            reg_addr      = RA_D;
            regfile_write = 1'b1;
         end
         ST_STR_0: begin
            memory_addr  = MA_OUT0;
            memory_write = 1'b1;
         end
         ST_MOV_0: begin
            reg_data      = RD_IMM;
            reg_addr      = RA_D;
            regfile_write = 1'b1;
         end
         ST_MVR_0: begin
            reg_data      = RD_OUT1;
            reg_addr      = RA_D;
            regfile_write = 1'b1;
         end
         ST_BRANCH_1: begin
            alu_in0       = IN0_PC;
            alu_in1       = IN1_INS;
            alu_op        = ALU_ADD;
            reg_data      = RD_ALU;
            reg_addr      = RA_PC;
            regfile_write = 1'b1;
         end
         default: ;
      endcase
   end

   assign state  = state_q;
   assign halted = (state_q == ST_HALT_0);

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Randomized bench: two controllers (MEM_WAIT 0 and 3) checked cycle by cycle against
// per-instruction expected output sequences expanded from the instruction set rules.
module tb_cpu_control_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_s [2];
   logic [3:0]  op_s  [2];
   logic [1:0]  st_s  [2];
   logic        res_s [2];
   logic        step_s;
   logic [20:0] obs   [2];

   int unsigned checks = 0;
   int unsigned errors = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [3:0] state;
      logic       halted, status_we, alu_in0, memory_write, ins_reg, regfile_write;
      logic [2:0] alu_op;
      logic [1:0] alu_in1, memory_addr, reg_data, reg_addr;

      cpu_control_fsm #(.MEM_WAIT(3 * g), .WAIT_W(4)) u_dut (
         .clk          (clk),
         .rst          (rst_s[g]),
         .opcode       (op_s[g]),
         .status       (st_s[g]),
         .resume       (res_s[g]),
         .step         (step_s),
         .state        (state),
         .halted       (halted),
         .status_we    (status_we),
         .alu_op       (alu_op),
         .alu_in0      (alu_in0),
         .alu_in1      (alu_in1),
         .memory_write (memory_write),
         .memory_addr  (memory_addr),
         .ins_reg      (ins_reg),
         .reg_data     (reg_data),
         .reg_addr     (reg_addr),
         .regfile_write(regfile_write)
      );

      assign obs[g] = {state, halted, status_we, alu_op, alu_in0, alu_in1, memory_write,
                       memory_addr, ins_reg, reg_data, reg_addr, regfile_write};
   end

   task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // {state, halted, status_we, alu_op, alu_in0, alu_in1, mem_we, mem_addr, ins_reg, reg_data, reg_addr, rf_we}
   function automatic logic [20:0] mk(input logic [3:0] s, input logic h, input logic swe,
                                      input logic [2:0] aop, input logic ai0, input logic [1:0] ai1,
                                      input logic mw, input logic [1:0] ma, input logic ir,
                                      input logic [1:0] rd, input logic [1:0] ra, input logic rw);
      return {s, h, swe, aop, ai0, ai1, mw, ma, ir, rd, ra, rw};
   endfunction

   logic [20:0] exp_q [$];

   task automatic build(input logic [3:0] op, input logic [1:0] sv, input int w, input int k,
                        input int nstep);
      logic       taken;
      logic [2:0] aop;
      exp_q.delete();
      repeat (w + 1) exp_q.push_back(mk(4'h0, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 2'd0, 0));
      exp_q.push_back(mk(4'h1, 0, 0, 3'd3, 1, 2'd2, 0, 2'd0, 1, 2'd2, 2'd2, 1));
      exp_q.push_back(mk(4'h2, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 2'd0, 0));
      if (op == 4'h0) begin
         repeat (k) exp_q.push_back(mk(4'h3, 1, 0, 3'd0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 2'd0, 0));
      end else if (op <= 4'h5 || op == 4'hA) begin
         aop = (op == 4'hA) ? 3'd4 : 3'(op - 4'd1);
         exp_q.push_back(mk(4'h4, 0, 1, aop, 0, 2'd0, 0, 2'd0, 0, 2'd0, 2'd0, 0));
         if (op != 4'hA)
            exp_q.push_back(mk(4'h5, 0, 0, aop, 0, 2'd0, 0, 2'd0, 0, 2'd2, 2'd0, 1));
      end else if (op == 4'h6) begin
         repeat (w + 1) exp_q.push_back(mk(4'h6, 0, 0, 3'd0, 0, 2'd0, 0, 2'd2, 0, 2'd0, 2'd0, 0));
         exp_q.push_back(mk(4'h7, 0, 0, 3'd0, 0, 2'd0, 0, 2'd2, 0, 2'd1, 2'd0, 1));
      end else if (op == 4'h7) begin
         exp_q.push_back(mk(4'h8, 0, 0, 3'd0, 0, 2'd0, 1, 2'd1, 0, 2'd0, 2'd0, 0));
      end else if (op == 4'h8) begin
         exp_q.push_back(mk(4'h9, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 2'd0, 1));
      end else if (op == 4'h9) begin
         exp_q.push_back(mk(4'hA, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 0, 2'd3, 2'd0, 1));
      end else begin
         case (op)
            4'hB:    taken = 1'b1;
            4'hC:    taken = sv[1];
            4'hD:    taken = !sv[1];
            4'hE:    taken = sv[0];
            default: taken = (sv == 2'b00);
         endcase
         exp_q.push_back(mk(4'hB, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 2'd0, 0));
         if (taken)
            exp_q.push_back(mk(4'hC, 0, 0, 3'd3, 1, 2'd1, 0, 2'd0, 0, 2'd2, 2'd2, 1));
      end
`ifdef FSM_STEP_EN
      repeat (nstep) exp_q.push_back(mk(4'hD, 0, 0, 3'd0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 2'd0, 0));
`else
      if (nstep < 0) exp_q.delete();
`endif
   endtask

   // Starts with the DUT in FETCH_0; leaves it in FETCH_0 of the next instruction.
   task automatic run(input int d, input logic [3:0] op, input logic [1:0] sv, input int k,
                      input int rst_at);
      int n;
      build(op, sv, 3 * d, k, $urandom_range(1, 3));
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         logic [3:0] es;
         logic       last;
         es = exp_q[i][20:17];
         chk($sformatf("d%0d op%h cyc%0d", d, op, i), obs[d], exp_q[i]);
         if (i == rst_at) begin
            rst_s[d] = 1'b1;
            res_s[d] = 1'b1;
            step_s   = 1'b1;
            @(posedge clk); #1;
            rst_s[d] = 1'b0;
            chk($sformatf("d%0d rst op%h cyc%0d", d, op, i), obs[d], '0);
            return;
         end
         last = 1'b1;
         if (i + 1 < n) last = (exp_q[i + 1][20:17] != es);
         op_s[d]  = (es <= 4'h2) ? op : 4'($urandom);
         st_s[d]  = (es == 4'hB) ? sv : 2'($urandom);
         res_s[d] = (es == 4'h3) ? last : 1'($urandom);
         step_s   = (es == 4'hD) ? last : 1'($urandom);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      step_s = 1'b0;
      for (int d = 0; d < 2; d++) begin
         rst_s[d] = 1'b1;
         op_s[d]  = 4'h0;
         st_s[d]  = 2'b00;
         res_s[d] = 1'b1;
      end
      for (int d = 0; d < 2; d++) begin
         repeat (2) @(posedge clk);
         #1;
         rst_s[d] = 1'b0;
         chk($sformatf("d%0d reset", d), obs[d], '0);
         run(d, 4'h4, 2'b00, 1, -1);
         run(d, 4'h6, 2'b00, 1, -1);
         run(d, 4'hC, 2'b00, 1, -1);
         run(d, 4'hC, 2'b10, 1, -1);
         run(d, 4'h0, 2'b00, 11, -1);
         run(d, 4'h0, 2'b00, 1, -1);
         run(d, 4'hA, 2'b00, 1, -1);
         run(d, 4'hF, 2'b00, 1, -1);
         run(d, 4'h6, 2'b00, 1, (d == 0) ? 3 : 8);
         run(d, 4'h6, 2'b00, 1, -1);
         run(d, 4'h0, 2'b00, 6, 3 * d + 5);
         for (int t = 0; t < 80; t++)
            run(d, 4'($urandom), 2'($urandom), $urandom_range(1, 4), -1);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
